// File: rtl/stack_ctrl_pkg.sv
// Shared encodings for the stack controller: command opcodes and FSM states.
package stack_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_PUSH    = 2'b00,
        OP_POP     = 2'b01,
        OP_REPLACE = 2'b10,
        OP_PEEK    = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EXEC   = 3'd1,
        S_RDWAIT = 3'd2,
        S_WRBACK = 3'd3,
        S_RESP   = 3'd4
    } state_e;

endpackage

// File: rtl/stack_sp.sv
// Stack pointer (next free slot) with full/empty decode; clear dominates,
// inc/dec are ignored at the boundaries so the pointer never wraps.
module stack_sp #(
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              inc,
    input  logic              dec,
    output logic [ADDR_W:0]   sp,
    output logic              empty,
    output logic              full
);

    localparam logic [ADDR_W:0] SP_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] SP_ONE = (ADDR_W+1)'(1);

    logic [ADDR_W:0] sp_q, sp_d;

    assign sp    = sp_q;
    assign empty = (sp_q == '0);
    assign full  = (sp_q == SP_MAX);

    always_comb begin
        sp_d = sp_q;
        if (clear)
            sp_d = '0;
        else if (inc && !full)
            sp_d = sp_q + SP_ONE;
        else if (dec && !empty)
            sp_d = sp_q - SP_ONE;
    end

    always_ff @(posedge clock) begin
        sp_q <= sp_d;
    end

endmodule

// File: rtl/stack_ctrl.sv
// Hardware stack controller over an external single-port RAM (1-cycle read).
// Define STACK_CTRL_PEEK_EN to enable op 11 (peek); otherwise it is rejected.
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   depth,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic [ADDR_W:0]   sp;
    logic              sp_inc, sp_dec;
    logic              exec_err;
    logic [ADDR_W-1:0] top_addr;
    logic              wren_raw;

    stack_sp #(.ADDR_W(ADDR_W)) u_sp (
        .clock (clock),
        .clear (reset),
        .inc   (sp_inc),
        .dec   (sp_dec),
        .sp    (sp),
        .empty (empty),
        .full  (full)
    );

    assign depth     = sp;
    // Low bits alone give the right slot even when full (sp = 2**ADDR_W).
    assign top_addr  = sp[ADDR_W-1:0] - ADDR_ONE;
    assign cmd_ready = (state_q == S_IDLE) && !reset;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
    assign mem_wren  = wren_raw && !reset;

    always_comb begin
        case (op_q)
            OP_PUSH: exec_err = full;
`ifdef STACK_CTRL_PEEK_EN
            OP_PEEK: exec_err = empty;
`else
            OP_PEEK: exec_err = 1'b1;
`endif
            default: exec_err = empty;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        sp_inc      = 1'b0;
        sp_dec      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        wren_raw    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = op_e'(cmd_op);
                    data_d  = cmd_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_err) begin
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (op_q == OP_PUSH) begin
                    mem_addr    = sp[ADDR_W-1:0];
                    mem_wdata   = data_q;
                    wren_raw    = 1'b1;
                    sp_inc      = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = data_q;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    mem_addr = top_addr;
                    state_d  = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                mem_addr   = top_addr;
                rsp_err_d  = 1'b0;
                rsp_data_d = mem_rdata;
                sp_dec     = (op_q == OP_POP);
                if (op_q == OP_REPLACE) begin
                    state_d = S_WRBACK;
                end else begin
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_WRBACK: begin
                mem_addr    = top_addr;
                mem_wdata   = data_q;
                wren_raw    = 1'b1;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        op_q   <= op_d;
        data_q <= data_d;
        if (reset) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, stack word width.
REQ-002 SHALL provide parameter ADDR_W, default 5, stack RAM address width (depth 2**ADDR_W).
REQ-003 SHALL provide port clock  input  1  rising-edge clock.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide cmd_valid  input  1, cmd_ready  output  1, cmd_op  input  2 (00 push, 01 pop, 10 replace, 11 peek), cmd_data  input  DATA_W.
REQ-006 SHALL provide rsp_valid  output  1, rsp_err  output  1, rsp_data  output  DATA_W.
REQ-007 SHALL provide empty  output  1, full  output  1, depth  output  ADDR_W+1.
REQ-008 SHALL provide mem_addr  output  ADDR_W, mem_wdata  output  DATA_W, mem_wren  output  1, mem_rdata  input  DATA_W (RAM read data valid one cycle after address).

Function
REQ-009 SHALL hold stack pointer sp (ADDR_W+1 bits, next free slot); depth=sp, empty=(sp==0), full=(sp==2**ADDR_W).
REQ-010 SHALL implement FSM states IDLE, EXEC, RDWAIT, WRBACK, RESP; cmd_ready=1 only in IDLE.
REQ-011 SHALL accept a command when cmd_valid&&cmd_ready, latching cmd_op/cmd_data, IDLE->EXEC.
REQ-012 Push, not full: EXEC drives mem_addr=sp, mem_wdata=latched data, mem_wren=1; sp<=sp+1; EXEC->RESP; rsp_data=pushed value.
REQ-013 Pop/peek/replace, not empty: EXEC drives mem_addr=sp-1, mem_wren=0; EXEC->RDWAIT; RDWAIT captures mem_rdata into rsp_data.
REQ-014 Pop: sp<=sp-1 in RDWAIT; peek: sp unchanged; both RDWAIT->RESP.
REQ-015 Replace: RDWAIT->WRBACK; WRBACK drives mem_addr=sp-1, mem_wdata=latched data, mem_wren=1; sp unchanged; WRBACK->RESP; rsp_data=old top.
REQ-016 Error (push when full; pop/peek/replace when empty): no RAM write, sp unchanged, EXEC->RESP, rsp_err=1, rsp_data=0.
REQ-017 RESP SHALL assert rsp_valid for exactly one cycle, then ->IDLE; rsp_data/rsp_err hold until next RESP.
REQ-018 Latency accept-to-rsp_valid: push 2 cycles, pop/peek 3, replace 4, error 2; throughput one command per response.
REQ-019 mem_wren SHALL be 1 only in EXEC (push) and WRBACK; mem_addr/mem_wdata SHALL be 0 in IDLE and RESP.
REQ-020 Push filling the last slot SHALL succeed and set full; pop of the last entry SHALL succeed and set empty; sp never wraps.

Reset
REQ-021 Reset SHALL force state IDLE, sp=0, rsp_valid=0, rsp_err=0, rsp_data=0, mem_wren=0; cmd_ready=0 while reset high, 1 the cycle after.
REQ-022 Reset mid-operation SHALL abort it: no pending write issued, no response, stack logically cleared.

Configuration
REQ-023 With STACK_CTRL_PEEK_EN defined, op 11 SHALL perform peek per REQ-013/014.
REQ-024 Without STACK_CTRL_PEEK_EN, op 11 SHALL take the error path (rsp_err=1, no RAM access, 2-cycle latency).

Structure
REQ-025 Op encodings and FSM state encoding SHALL live in shared package stack_ctrl_pkg.
REQ-026 sp counter with full/empty decode SHALL be sub-module stack_sp (inc, dec, clear inputs).

Verification
REQ-027 After reset push 0x1234 -> mem_wren=1 at addr 0 with 0x1234; rsp_valid 2 cycles after accept; depth=1.
REQ-028 Push 0xAAAA, 0x5555; pop -> rsp_data=0x5555 3 cycles after accept, depth=1; pop -> 0xAAAA, empty=1.
REQ-029 Stack [0x0003]; replace 0x0009 -> rsp_data=0x0003, WRBACK writes 0x0009 at addr 0, depth stays 1; peek -> 0x0009.
REQ-030 Push 32 values -> full=1; 33rd push -> rsp_err=1, no mem_wren, depth=32; pop on empty -> rsp_err=1, rsp_data=0.
REQ-031 Assert reset during replace RDWAIT -> no WRBACK write, rsp_valid stays 0, depth=0, cmd_ready=1 next cycle.
REQ-032 Build without STACK_CTRL_PEEK_EN, stack non-empty, op 11 -> rsp_err=1 after 2 cycles, depth unchanged.
